// File: rtl/psram_responder.sv
// QPI PSRAM device emulator: serial 35h enters QPI; EBh/38h/F5h in QPI mode; byte-wide internal RAM.
// Optional protocol checking is built when PSRAM_RESPONDER_PROTOCOL_CHECK_EN is defined.
module psram_responder #(
    parameter int ADDR_W      = 16,
    parameter int WAIT_CYCLES = 6,
    parameter int SYNC_STAGES = 2
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_psram_csn,
    input  logic       i_psram_sclk,
    input  logic [3:0] i_psram_sio,
    output logic [3:0] o_psram_sio,
    output logic       o_psram_sio_oe,
    output logic       o_qpi_mode,
    output logic       o_err
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int CNT_W = $clog2(WAIT_CYCLES + 8);

    typedef enum logic [2:0] {
        CMD, ADDR, WAIT, RD_DATA, WR_DATA, IGNORE
    } state_t;

    logic [SYNC_STAGES-1:0]      csn_sync_q, sclk_sync_q;
    logic [SYNC_STAGES-1:0][3:0] sio_sync_q;
    logic                        csn_s, sclk_s;
    logic [3:0]                  sio_s;
    logic                        sclk_prev_q, sclk_rise, sclk_fall;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [6:0]         shift_q, shift_d;
    logic               is_read_q, is_read_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic               qpi_q, qpi_d;
    logic [3:0]         dout_q, dout_d;
    logic               oe_q, oe_d;
    logic [3:0]         wr_hi_q, wr_hi_d;
    logic               nib_q, nib_d;
    logic [7:0]         cmd_byte;
    logic               cmd_done;

    logic [7:0]         mem [DEPTH];
    logic [7:0]         rd_data_q;
    logic               rd_en, wr_en;
    logic [ADDR_W-1:0]  rd_addr;
    logic [7:0]         wr_data;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            csn_sync_q  <= '1;
            sclk_sync_q <= '0;
            sio_sync_q  <= '0;
            sclk_prev_q <= 1'b0;
        end else begin
            csn_sync_q[0]  <= i_psram_csn;
            sclk_sync_q[0] <= i_psram_sclk;
            sio_sync_q[0]  <= i_psram_sio;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                csn_sync_q[i]  <= csn_sync_q[i-1];
                sclk_sync_q[i] <= sclk_sync_q[i-1];
                sio_sync_q[i]  <= sio_sync_q[i-1];
            end
            sclk_prev_q <= sclk_s;
        end
    end

    assign csn_s     = csn_sync_q[SYNC_STAGES-1];
    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign sio_s     = sio_sync_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev_q;
    assign sclk_fall = ~sclk_s & sclk_prev_q;

    // Serial mode shifts one bit per rise, QPI mode one nibble per rise.
    assign cmd_byte = qpi_q ? {shift_q[3:0], sio_s} : {shift_q, sio_s[0]};
    assign cmd_done = qpi_q ? (cnt_q == CNT_W'(1)) : (cnt_q == CNT_W'(7));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= CMD;
            cnt_q     <= '0;
            shift_q   <= '0;
            is_read_q <= 1'b0;
            addr_q    <= '0;
            qpi_q     <= 1'b0;
            dout_q    <= '0;
            oe_q      <= 1'b0;
            wr_hi_q   <= '0;
            nib_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shift_q   <= shift_d;
            is_read_q <= is_read_d;
            addr_q    <= addr_d;
            qpi_q     <= qpi_d;
            dout_q    <= dout_d;
            oe_q      <= oe_d;
            wr_hi_q   <= wr_hi_d;
            nib_q     <= nib_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shift_d   = shift_q;
        is_read_d = is_read_q;
        addr_d    = addr_q;
        qpi_d     = qpi_q;
        dout_d    = dout_q;
        oe_d      = oe_q;
        wr_hi_d   = wr_hi_q;
        nib_d     = nib_q;
        rd_en     = 1'b0;
        rd_addr   = addr_q;
        wr_en     = 1'b0;
        wr_data   = {wr_hi_q, sio_s};

        // Deselect wins over any coincident sclk edge, so no write can slip through.
        if (csn_s) begin
            state_d = CMD;
            cnt_d   = '0;
            nib_d   = 1'b0;
            oe_d    = 1'b0;
            dout_d  = '0;
        end else begin
            unique case (state_q)
                CMD: if (sclk_rise) begin
                    shift_d = cmd_byte[6:0];
                    cnt_d   = cnt_q + 1'b1;
                    if (cmd_done) begin
                        cnt_d   = '0;
                        state_d = IGNORE;
                        if (!qpi_q) begin
                            if (cmd_byte == 8'h35) qpi_d = 1'b1;
                        end else begin
                            unique case (cmd_byte)
                                8'hEB: begin state_d = ADDR; is_read_d = 1'b1; end
                                8'h38: begin state_d = ADDR; is_read_d = 1'b0; end
                                8'hF5: qpi_d = 1'b0;
                                default: ;
                            endcase
                        end
                    end
                end
                ADDR: if (sclk_rise) begin
                    addr_d = ADDR_W'({addr_q, sio_s});
                    cnt_d  = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(5)) begin
                        cnt_d   = '0;
                        nib_d   = 1'b0;
                        state_d = is_read_q ? WAIT : WR_DATA;
                    end
                end
                WAIT: if (sclk_rise) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(WAIT_CYCLES - 1)) begin
                        cnt_d   = '0;
                        nib_d   = 1'b0;
                        rd_en   = 1'b1;
                        state_d = RD_DATA;
                    end
                end
                // Prefetch the next byte while its predecessor's low nibble goes out.
                RD_DATA: if (sclk_fall) begin
                    oe_d = 1'b1;
                    if (!nib_q) begin
                        dout_d = rd_data_q[7:4];
                        nib_d  = 1'b1;
                    end else begin
                        dout_d  = rd_data_q[3:0];
                        nib_d   = 1'b0;
                        addr_d  = addr_q + 1'b1;
                        rd_en   = 1'b1;
                        rd_addr = addr_q + 1'b1;
                    end
                end
                WR_DATA: if (sclk_rise) begin
                    if (!nib_q) begin
                        wr_hi_d = sio_s;
                        nib_d   = 1'b1;
                    end else begin
                        wr_en  = 1'b1;
                        nib_d  = 1'b0;
                        addr_d = addr_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Storage is deliberately left uninitialised across reset.
    always_ff @(posedge i_clk) begin
        if (wr_en) mem[addr_q] <= wr_data;
        if (rd_en) rd_data_q <= mem[rd_addr];
    end

    assign o_psram_sio    = dout_q;
    assign o_psram_sio_oe = oe_q;
    assign o_qpi_mode     = qpi_q;

`ifdef PSRAM_RESPONDER_PROTOCOL_CHECK_EN
    logic csn_prev_q, err_q, err_d, cmd_known, csn_rise;

    assign csn_rise  = csn_s & ~csn_prev_q;
    assign cmd_known = qpi_q ? (cmd_byte == 8'hEB || cmd_byte == 8'h38 || cmd_byte == 8'hF5)
                             : (cmd_byte == 8'h35);

    always_comb begin
        err_d = err_q;
        if (csn_rise && (state_q == ADDR || state_q == WAIT || (state_q == WR_DATA && nib_q)))
            err_d = 1'b1;
        if (csn_s && csn_prev_q && (sclk_rise || sclk_fall))
            err_d = 1'b1;
        if (!csn_s && sclk_rise && state_q == CMD && cmd_done && !cmd_known)
            err_d = 1'b1;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            csn_prev_q <= 1'b1;
            err_q      <= 1'b0;
        end else begin
            csn_prev_q <= csn_s;
            err_q      <= err_d;
        end
    end

    assign o_err = err_q;
`else
    assign o_err = 1'b0;
`endif

endmodule

// File: tb/tb_psram_responder.sv
// Scoreboard bench for psram_responder: randomized QPI bursts checked against a byte-array memory model.
module tb_psram_responder;

    localparam int ADDR_W      = 16;
    localparam int WAIT_CYCLES = 6;
    localparam int SYNC_STAGES = 2;
    localparam int DEPTH       = 1 << ADDR_W;
    localparam int HALF        = 5;

    logic       i_clk = 1'b0;
    logic       i_rst;
    logic       i_psram_csn;
    logic       i_psram_sclk;
    logic [3:0] i_psram_sio;
    logic [3:0] o_psram_sio;
    logic       o_psram_sio_oe;
    logic       o_qpi_mode;
    logic       o_err;

    int         checks   = 0;
    int         failures = 0;
    logic [3:0] expQ[$];
    bit         expectOe = 1'b0;
    logic [7:0] refMem [DEPTH];
    bit         refQpi = 1'b0;
    bit         refErr = 1'b0;

    always #5 i_clk = ~i_clk;

    psram_responder #(
        .ADDR_W(ADDR_W), .WAIT_CYCLES(WAIT_CYCLES), .SYNC_STAGES(SYNC_STAGES)
    ) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_psram_csn(i_psram_csn), .i_psram_sclk(i_psram_sclk),
        .i_psram_sio(i_psram_sio), .o_psram_sio(o_psram_sio), .o_psram_sio_oe(o_psram_sio_oe),
        .o_qpi_mode(o_qpi_mode), .o_err(o_err)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Monitor: every bench sclk rise is the controller's sample point for read data.
    initial begin
        logic [3:0] e;
        forever begin
            @(posedge i_psram_sclk);
            checkOutput("oe_at_rise", {31'b0, o_psram_sio_oe}, {31'b0, expectOe});
            if (expectOe && o_psram_sio_oe) begin
                if (expQ.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL read_underflow actual=%0h expected=none", o_psram_sio);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("read_nibble", {28'b0, o_psram_sio}, {28'b0, e});
                end
            end
        end
    end

    initial begin
        #800000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // One full sclk period: fall with new data, then rise where the DUT samples.
    task automatic applyStimulus(input logic [3:0] sio);
        i_psram_sclk = 1'b0;
        i_psram_sio  = sio;
        repeat (HALF) @(negedge i_clk);
        i_psram_sclk = 1'b1;
        repeat (HALF) @(negedge i_clk);
    endtask

    task automatic csnLow();
        i_psram_csn = 1'b0;
        repeat (HALF) @(negedge i_clk);
    endtask

    task automatic csnHigh(input bit readEnd);
        expectOe     = 1'b0;
        i_psram_sclk = 1'b0;
        repeat (HALF) @(negedge i_clk);
        if (readEnd) checkOutput("oe_before_csn_rise", {31'b0, o_psram_sio_oe}, 32'd1);
        i_psram_csn = 1'b1;
        if (readEnd) begin
            repeat (SYNC_STAGES) @(posedge i_clk);
            @(negedge i_clk);
            checkOutput("oe_held_during_sync", {31'b0, o_psram_sio_oe}, 32'd1);
            @(posedge i_clk);
            @(negedge i_clk);
            checkOutput("oe_release", {31'b0, o_psram_sio_oe}, 32'd0);
        end
        repeat (2 * HALF) @(negedge i_clk);
    endtask

    task automatic sendSerial(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) applyStimulus({3'b0, b[i]});
    endtask

    task automatic sendQpiByte(input logic [7:0] b);
        applyStimulus(b[7:4]);
        applyStimulus(b[3:0]);
    endtask

    task automatic sendAddr(input logic [23:0] a);
        for (int i = 5; i >= 0; i--) applyStimulus(a[i*4 +: 4]);
    endtask

    task automatic enterQpi();
        csnLow();
        sendSerial(8'h35);
        refQpi = 1'b1;
        checkOutput("qpi_after_35", {31'b0, o_qpi_mode}, {31'b0, refQpi});
        csnHigh(1'b0);
    endtask

    task automatic writeBurst(input logic [23:0] a, input logic [7:0] data[$],
                              input bit extra, input logic [3:0] extraNib);
        int idx;
        csnLow();
        sendQpiByte(8'h38);
        sendAddr(a);
        for (int i = 0; i < data.size(); i++) begin
            sendQpiByte(data[i]);
            idx = (int'(a) + i) % DEPTH;
            refMem[idx] = data[i];
        end
        if (extra) begin
            applyStimulus(extraNib);
`ifdef PSRAM_RESPONDER_PROTOCOL_CHECK_EN
            refErr = 1'b1;
`endif
        end
        csnHigh(1'b0);
    endtask

    task automatic readBurst(input logic [23:0] a, input int n);
        int idx;
        csnLow();
        sendQpiByte(8'hEB);
        sendAddr(a);
        for (int i = 0; i < n; i++) begin
            idx = (int'(a) + i) % DEPTH;
            expQ.push_back(refMem[idx][7:4]);
            expQ.push_back(refMem[idx][3:0]);
        end
        repeat (WAIT_CYCLES) applyStimulus(4'h0);
        expectOe = 1'b1;
        repeat (2 * n) applyStimulus(4'h0);
        csnHigh(1'b1);
    endtask

    initial begin
        logic [7:0]  d[$];
        logic [23:0] a;
        int          len, rlen, off;
        bit          extra;

        i_rst = 1'b1; i_psram_csn = 1'b1; i_psram_sclk = 1'b0; i_psram_sio = 4'h0;
        repeat (4) @(negedge i_clk);
        checkOutput("reset_oe", {31'b0, o_psram_sio_oe}, 32'd0);
        checkOutput("reset_sio", {28'b0, o_psram_sio}, 32'd0);
        checkOutput("reset_qpi", {31'b0, o_qpi_mode}, 32'd0);
        checkOutput("reset_err", {31'b0, o_err}, 32'd0);
        i_rst = 1'b0;
        repeat (4) @(negedge i_clk);

        enterQpi();

        d.delete(); d.push_back(8'hA5); d.push_back(8'h3C);
        writeBurst(24'h000010, d, 1'b0, 4'h0);
        readBurst(24'h000010, 2);

        d.delete(); d.push_back(8'h11); d.push_back(8'h22);
        writeBurst(24'h00FFFF, d, 1'b0, 4'h0);
        readBurst(24'h00FFFF, 2);
        d.delete(); d.push_back(8'h77);
        writeBurst(24'h12FFFF, d, 1'b0, 4'h0);
        readBurst(24'h00FFFF, 2);

        d.delete(); d.push_back(8'h5A);
        writeBurst(24'h000021, d, 1'b0, 4'h0);
        d.delete(); d.push_back(8'hC3);
        writeBurst(24'h000020, d, 1'b1, 4'h9);
        readBurst(24'h000020, 2);
        checkOutput("err_after_partial", {31'b0, o_err}, {31'b0, refErr});

        csnLow();
        sendQpiByte(8'hF5);
        refQpi = 1'b0;
        checkOutput("qpi_after_f5", {31'b0, o_qpi_mode}, {31'b0, refQpi});
        csnHigh(1'b0);

        // In serial mode these nibbles form byte 42h on sio[0] and must be ignored.
        csnLow();
        sendQpiByte(8'hEB);
        sendAddr(24'h000010);
        repeat (WAIT_CYCLES + 4) applyStimulus(4'h0);
`ifdef PSRAM_RESPONDER_PROTOCOL_CHECK_EN
        refErr = 1'b1;
`endif
        csnHigh(1'b0);
        checkOutput("qpi_stays_off", {31'b0, o_qpi_mode}, {31'b0, refQpi});

        enterQpi();

        for (int t = 0; t < 24; t++) begin
            a = 24'($urandom());
            if ($urandom_range(0, 3) == 0) a[15:0] = 16'hFFFE;
            len   = $urandom_range(1, 4);
            extra = ($urandom_range(0, 3) == 0);
            d.delete();
            for (int i = 0; i < len; i++) d.push_back(8'($urandom()));
            writeBurst(a, d, extra, 4'($urandom()));
            rlen = $urandom_range(1, len);
            off  = $urandom_range(0, len - rlen);
            readBurst(a + 24'(off), rlen);
        end
        checkOutput("err_after_random", {31'b0, o_err}, {31'b0, refErr});

        csnLow();
        sendQpiByte(8'hEB);
        sendAddr(24'h000010);
        expQ.push_back(refMem[16][7:4]);
        expQ.push_back(refMem[16][3:0]);
        repeat (WAIT_CYCLES) applyStimulus(4'h0);
        expectOe = 1'b1;
        repeat (2) applyStimulus(4'h0);
        expectOe = 1'b0;
        checkOutput("oe_before_reset", {31'b0, o_psram_sio_oe}, 32'd1);
        i_rst = 1'b1;
        @(posedge i_clk);
        @(negedge i_clk);
        refQpi = 1'b0;
        refErr = 1'b0;
        checkOutput("oe_after_reset", {31'b0, o_psram_sio_oe}, 32'd0);
        checkOutput("sio_after_reset", {28'b0, o_psram_sio}, 32'd0);
        checkOutput("qpi_after_reset", {31'b0, o_qpi_mode}, {31'b0, refQpi});
        i_rst = 1'b0;
        i_psram_sclk = 1'b0;
        repeat (HALF) @(negedge i_clk);
        i_psram_csn = 1'b1;
        repeat (2 * HALF) @(negedge i_clk);

        checkOutput("final_qpi", {31'b0, o_qpi_mode}, {31'b0, refQpi});
        checkOutput("final_err", {31'b0, o_err}, {31'b0, refErr});
        checkOutput("scoreboard_empty", expQ.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
